// File: rtl/mfp_ahb_load_master.sv
// AHB-Lite bus-ownership arbiter between the CPU master and the serial loader,
// with a byte-write FIFO that issues pipelined single-byte AHB-Lite writes.
module mfp_ahb_load_master #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned ERR_W       = 8
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          SI_Endian,
  input  logic                          ld_active,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [31:0]                   ld_addr,
  input  logic [7:0]                    ld_byte,
  input  logic [31:0]                   cpu_HADDR,
  input  logic [2:0]                    cpu_HBURST,
  input  logic                          cpu_HMASTLOCK,
  input  logic [3:0]                    cpu_HPROT,
  input  logic [2:0]                    cpu_HSIZE,
  input  logic [1:0]                    cpu_HTRANS,
  input  logic [31:0]                   cpu_HWDATA,
  input  logic                          cpu_HWRITE,
  input  logic                          HREADY,
  input  logic                          HRESP,
  output logic [31:0]                   HADDR,
  output logic [2:0]                    HBURST,
  output logic                          HMASTLOCK,
  output logic [3:0]                    HPROT,
  output logic [2:0]                    HSIZE,
  output logic [1:0]                    HTRANS,
  output logic [31:0]                   HWDATA,
  output logic                          HWRITE,
  output logic                          cpu_hold,
  output logic                          loader_owns,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [ERR_W-1:0]              err_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    S_CPU        = 2'd0,
    S_GRANT_WAIT = 2'd1,
    S_LOAD       = 2'd2,
    S_RELEASE    = 2'd3
  } state_t;

  state_t         state;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [31:0]    fifo_addr [FIFO_DEPTH];
  logic [7:0]     fifo_data [FIFO_DEPTH];
  logic [CW-1:0]  hold_cnt;
  logic           dp_loader;
  logic           ld_dp;
  logic [31:0]    ld_wdata;

  logic           full;
  logic           empty;
  logic           push;
  logic           issue;
  logic           pop;
  logic [31:0]    head_addr;
  logic [7:0]     head_byte;
  logic [1:0]     lane;

  assign full      = (fifo_level == LW'(FIFO_DEPTH));
  assign empty     = (fifo_level == '0);
  assign ld_ready  = !full;
  assign push      = ld_valid && !full;
  assign head_addr = fifo_addr[rd_ptr];
  assign head_byte = fifo_data[rd_ptr];
  assign issue     = (state == S_LOAD) && !empty && !HRESP;
  assign pop       = issue && HREADY;
  assign lane      = SI_Endian ? ~head_addr[1:0] : head_addr[1:0];

  assign cpu_hold    = (state != S_CPU);
  assign loader_owns = (state == S_LOAD);

  // FIFO storage; validity is tracked by the pointers, so no reset needed
  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_addr[wr_ptr] <= ld_addr;
      fifo_data[wr_ptr] <= ld_byte;
    end
  end

  // Ownership FSM, FIFO bookkeeping, data-phase tracking and error counting
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= S_CPU;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      err_count  <= '0;
      hold_cnt   <= '0;
      dp_loader  <= 1'b0;
      ld_dp      <= 1'b0;
      ld_wdata   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: ;
      endcase
      if (ld_valid && full) overflow <= 1'b1;

      if (pop) ld_wdata <= {24'h0, head_byte} << {lane, 3'b000};

      // Data-phase ownership only advances when the slave accepts a phase
      if (HREADY) begin
        dp_loader <= (state == S_LOAD);
        ld_dp     <= pop;
      end

      // First cycle of a two-cycle error response counts once
      if (ld_dp && HRESP && !HREADY && (err_count != '1))
        err_count <= err_count + ERR_W'(1);

      unique case (state)
        S_CPU: begin
          if (ld_active) state <= S_GRANT_WAIT;
        end
        S_GRANT_WAIT: begin
          if (HREADY) state <= S_LOAD;
        end
        S_LOAD: begin
          if (!ld_active && empty && HREADY) begin
            state    <= S_RELEASE;
            hold_cnt <= '0;
          end
        end
        S_RELEASE: begin
          if (ld_active) begin
            state    <= S_LOAD;
            hold_cnt <= '0;
          end else if (hold_cnt == CW'(HOLD_CYCLES)) begin
            state <= S_CPU;
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: state <= S_CPU;
      endcase
    end
  end

  // Master-side bus mux
  always_comb begin
    HADDR     = cpu_HADDR;
    HBURST    = cpu_HBURST;
    HMASTLOCK = cpu_HMASTLOCK;
    HPROT     = cpu_HPROT;
    HSIZE     = cpu_HSIZE;
    HTRANS    = cpu_HTRANS;
    HWRITE    = cpu_HWRITE;
    HWDATA    = dp_loader ? ld_wdata : cpu_HWDATA;
    unique case (state)
      S_CPU: HWDATA = cpu_HWDATA;
      S_GRANT_WAIT, S_RELEASE: HTRANS = TRANS_IDLE;
      S_LOAD: begin
        HADDR     = head_addr;
        HBURST    = 3'b000;
        HMASTLOCK = 1'b0;
        HPROT     = 4'b0011;
        HSIZE     = 3'b000;
        HWRITE    = 1'b1;
        HTRANS    = issue ? TRANS_NONSEQ : TRANS_IDLE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mfp_ahb_load_master.sv
// Directed self-checking bench for mfp_ahb_load_master.
module tb_mfp_ahb_load_master;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned HOLD       = 16;
  localparam int unsigned ERR_W      = 8;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        SI_Endian;
  logic        ld_active;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [7:0]  ld_byte;
  logic [31:0] cpu_HADDR;
  logic [2:0]  cpu_HBURST;
  logic        cpu_HMASTLOCK;
  logic [3:0]  cpu_HPROT;
  logic [2:0]  cpu_HSIZE;
  logic [1:0]  cpu_HTRANS;
  logic [31:0] cpu_HWDATA;
  logic        cpu_HWRITE;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        cpu_hold;
  logic        loader_owns;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic        overflow;
  logic [ERR_W-1:0] err_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 HCLK = ~HCLK;

  mfp_ahb_load_master #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .HOLD_CYCLES(HOLD),
    .ERR_W      (ERR_W)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .SI_Endian    (SI_Endian),
    .ld_active    (ld_active),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_addr      (ld_addr),
    .ld_byte      (ld_byte),
    .cpu_HADDR    (cpu_HADDR),
    .cpu_HBURST   (cpu_HBURST),
    .cpu_HMASTLOCK(cpu_HMASTLOCK),
    .cpu_HPROT    (cpu_HPROT),
    .cpu_HSIZE    (cpu_HSIZE),
    .cpu_HTRANS   (cpu_HTRANS),
    .cpu_HWDATA   (cpu_HWDATA),
    .cpu_HWRITE   (cpu_HWRITE),
    .HREADY       (HREADY),
    .HRESP        (HRESP),
    .HADDR        (HADDR),
    .HBURST       (HBURST),
    .HMASTLOCK    (HMASTLOCK),
    .HPROT        (HPROT),
    .HSIZE        (HSIZE),
    .HTRANS       (HTRANS),
    .HWDATA       (HWDATA),
    .HWRITE       (HWRITE),
    .cpu_hold     (cpu_hold),
    .loader_owns  (loader_owns),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .err_count    (err_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 2 units later
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Push four bytes at 0..3 starting this cycle and follow the pipelined writes
  task automatic load4(input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] exp [4];
    exp = '{e0, e1, e2, e3};
    for (int k = 0; k < 6; k++) begin
      ld_valid = (k < 4);
      ld_addr  = 32'(k);
      ld_byte  = 8'((k + 1) * 17);
      settle();
      if (k >= 1 && k <= 4) begin
        check("burst_htrans", 64'(HTRANS), 64'(2'b10));
        check("burst_haddr", 64'(HADDR), 64'(k - 1));
        check("burst_hsize_hwrite", 64'({HSIZE, HWRITE, HPROT}), 64'({3'b000, 1'b1, 4'b0011}));
      end
      if (k >= 2) check("burst_hwdata", 64'(HWDATA), 64'(exp[k-2]));
      if (k == 5) check("burst_idle", 64'(HTRANS), 64'(2'b00));
      tick();
    end
  endtask

  // Current cycle ends the final loader data phase with ld_active low
  task automatic release_check();
    tick();
    repeat (HOLD) tick();
    check("release_hold_last", 64'(cpu_hold), 64'(1));
    check("release_htrans", 64'(HTRANS), 64'(2'b00));
    tick();
    check("release_hold_drop", 64'(cpu_hold), 64'(0));
    check("release_owns", 64'(loader_owns), 64'(0));
  endtask

  initial begin
    HRESET = 1'b1; SI_Endian = 1'b0; ld_active = 1'b0; ld_valid = 1'b0;
    ld_addr = '0; ld_byte = '0;
    cpu_HADDR = '0; cpu_HBURST = '0; cpu_HMASTLOCK = 1'b0; cpu_HPROT = '0;
    cpu_HSIZE = '0; cpu_HTRANS = '0; cpu_HWDATA = '0; cpu_HWRITE = 1'b0;
    HREADY = 1'b1; HRESP = 1'b0;
    #3;
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_ready", 64'(ld_ready), 64'(1));
    check("rst_hold", 64'(cpu_hold), 64'(0));
    check("rst_owns", 64'(loader_owns), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    check("rst_err", 64'(err_count), 64'(0));
    tick();
    HRESET = 1'b0;

    // CPU passthrough read
    cpu_HTRANS = 2'b10; cpu_HADDR = 32'hBF80_0000; cpu_HSIZE = 3'b010;
    settle();
    check("cpu_haddr", 64'(HADDR), 64'h0000_0000_BF80_0000);
    check("cpu_htrans", 64'(HTRANS), 64'(2'b10));
    check("cpu_hsize", 64'(HSIZE), 64'(3'b010));
    check("cpu_hold_low", 64'(cpu_hold), 64'(0));
    tick();

    // Loader session request; cpu_hold rises one cycle later
    ld_active = 1'b1;
    settle();
    check("req_hold_still_low", 64'(cpu_hold), 64'(0));
    tick();
    check("grant_hold_high", 64'(cpu_hold), 64'(1));
    check("grant_htrans_idle", 64'(HTRANS), 64'(2'b00));
    check("grant_not_owned", 64'(loader_owns), 64'(0));
    cpu_HTRANS = 2'b00;

    load4(32'h0000_0011, 32'h0000_2200, 32'h0033_0000, 32'h4400_0000);
    SI_Endian = 1'b1;
    load4(32'h1100_0000, 32'h0022_0000, 32'h0000_3300, 32'h0000_0044);
    SI_Endian = 1'b0;

    // Three wait states on the second transfer's data phase
    ld_valid = 1'b1; ld_addr = 32'h100; ld_byte = 8'hA0;
    tick();
    ld_addr = 32'h101; ld_byte = 8'hA1;
    settle();
    check("stall_a0_addr", 64'(HADDR), 64'h100);
    tick();
    ld_addr = 32'h102; ld_byte = 8'hA2;
    settle();
    check("stall_a0_data", 64'(HWDATA), 64'h0000_00A0);
    check("stall_a1_addr", 64'(HADDR), 64'h101);
    tick();
    ld_valid = 1'b0; HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall_htrans", 64'(HTRANS), 64'(2'b10));
      check("stall_haddr", 64'(HADDR), 64'h102);
      check("stall_hwdata", 64'(HWDATA), 64'h0000_A100);
      check("stall_level", 64'(fifo_level), 64'(1));
      tick();
    end
    HREADY = 1'b1;
    settle();
    check("stall_resume_addr", 64'(HADDR), 64'h102);
    tick();
    settle();
    check("stall_a2_data", 64'(HWDATA), 64'h00A2_0000);
    check("stall_empty", 64'(fifo_level), 64'(0));
    check("stall_idle", 64'(HTRANS), 64'(2'b00));
    tick();

    // Fill under a long stall, then overflow and drain
    HREADY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1'b1; ld_addr = 32'h200 + 32'(i); ld_byte = 8'hB0 + 8'(i);
      settle();
      if (i == 8) begin
        check("fill_level", 64'(fifo_level), 64'(8));
        check("fill_ready", 64'(ld_ready), 64'(0));
        check("fill_no_ovf", 64'(overflow), 64'(0));
        check("fill_head_addr", 64'(HADDR), 64'h200);
      end
      if (i == 9) check("fill_ovf", 64'(overflow), 64'(1));
      tick();
    end
    ld_valid = 1'b0; HREADY = 1'b1;
    for (int i = 0; i < 9; i++) begin
      settle();
      if (i == 0) begin
        check("drain_full_ready", 64'(ld_ready), 64'(0));
        check("drain_full_level", 64'(fifo_level), 64'(8));
      end
      if (i == 1) begin
        check("drain_ready", 64'(ld_ready), 64'(1));
        check("drain_first_data", 64'(HWDATA), 64'h0000_00B0);
      end
      if (i < 8) check("drain_haddr", 64'(HADDR), 64'h200 + 64'(i));
      if (i == 8) begin
        check("drain_last_data", 64'(HWDATA), 64'hB700_0000);
        check("drain_level", 64'(fifo_level), 64'(0));
      end
      tick();
    end

    // Two-cycle error on the first of two loader writes
    ld_valid = 1'b1; ld_addr = 32'h300; ld_byte = 8'hC0;
    tick();
    ld_addr = 32'h301; ld_byte = 8'hC1;
    settle();
    check("err_c0_addr", 64'(HADDR), 64'h300);
    check("err_c0_trans", 64'(HTRANS), 64'(2'b10));
    tick();
    ld_valid = 1'b0; HRESP = 1'b1; HREADY = 1'b0;
    settle();
    check("err_cyc1_idle", 64'(HTRANS), 64'(2'b00));
    check("err_c0_data", 64'(HWDATA), 64'h0000_00C0);
    tick();
    HREADY = 1'b1;
    settle();
    check("err_cyc2_idle", 64'(HTRANS), 64'(2'b00));
    check("err_count_one", 64'(err_count), 64'(1));
    tick();
    HRESP = 1'b0;
    settle();
    check("err_next_trans", 64'(HTRANS), 64'(2'b10));
    check("err_next_addr", 64'(HADDR), 64'h301);
    check("err_count_hold", 64'(err_count), 64'(1));
    tick();
    ld_active = 1'b0;
    settle();
    check("err_c1_data", 64'(HWDATA), 64'h0000_C100);
    release_check();

    // CPU data phase stalled when the loader session begins
    cpu_HTRANS = 2'b10; cpu_HADDR = 32'h1000; cpu_HWRITE = 1'b1; HREADY = 1'b1;
    settle();
    check("cpu_wr_addr", 64'(HADDR), 64'h1000);
    tick();
    cpu_HWDATA = 32'hDEAD_BEEF; HREADY = 1'b0; ld_active = 1'b1;
    settle();
    check("cpu_wr_data", 64'(HWDATA), 64'hDEAD_BEEF);
    tick();
    ld_valid = 1'b1; ld_addr = 32'h400; ld_byte = 8'hD5;
    settle();
    check("gw_hold", 64'(cpu_hold), 64'(1));
    check("gw_idle", 64'(HTRANS), 64'(2'b00));
    check("gw_cpu_data", 64'(HWDATA), 64'hDEAD_BEEF);
    check("gw_owns", 64'(loader_owns), 64'(0));
    tick();
    ld_valid = 1'b0; HREADY = 1'b1;
    settle();
    check("gw_ready_idle", 64'(HTRANS), 64'(2'b00));
    check("gw_ready_data", 64'(HWDATA), 64'hDEAD_BEEF);
    check("gw_level", 64'(fifo_level), 64'(1));
    tick();
    cpu_HTRANS = 2'b00;
    settle();
    check("load_owns", 64'(loader_owns), 64'(1));
    check("load_nonseq", 64'(HTRANS), 64'(2'b10));
    check("load_addr", 64'(HADDR), 64'h400);
    tick();
    ld_active = 1'b0;
    settle();
    check("load_data", 64'(HWDATA), 64'h0000_00D5);
    release_check();

    // Asynchronous reset in the middle of a session
    ld_active = 1'b1; HREADY = 1'b0;
    tick();
    ld_valid = 1'b1; ld_addr = 32'h500; ld_byte = 8'hE0;
    tick();
    tick();
    ld_valid = 1'b0; cpu_HTRANS = 2'b10; cpu_HADDR = 32'hBF80_0000;
    settle();
    check("mid_level", 64'(fifo_level), 64'(2));
    check("mid_hold", 64'(cpu_hold), 64'(1));
    HRESET = 1'b1;
    #1;
    check("arst_level", 64'(fifo_level), 64'(0));
    check("arst_hold", 64'(cpu_hold), 64'(0));
    check("arst_ovf", 64'(overflow), 64'(0));
    check("arst_err", 64'(err_count), 64'(0));
    check("arst_haddr", 64'(HADDR), 64'h0000_0000_BF80_0000);
    check("arst_htrans", 64'(HTRANS), 64'(2'b10));
    tick();
    HRESET = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
